// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
// Front end for the DE1-SoC 4-bit ALU. It debounces the enter and clear
// pushbuttons, then latches operand A, operand B and the function code from
// the switches one step at a time. It also captures the ALU result for the
// displays.
// Optional feature macro: ALU_SEQ_CHAIN_EN. When it is defined, enter in SHOW
// chains result[3:0] into A and jumps straight to GET_B.
module alu_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] key_n,
    input  logic [3:0] sw,
    input  logic [7:0] alu_out,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [2:0] Function,
    output logic [7:0] result,
    output logic [2:0] state,
    output logic       done
);

    // Counter wide enough to reach DEBOUNCE_CYCLES-1 (minimum 2 cycles).
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_F   = 3'd2,
        CAPTURE = 3'd3,
        SHOW    = 3'd4
    } seq_state_t;

    logic [1:0] key_meta_r;
    logic [1:0] key_sync_r;
    logic [1:0] press_s;

    seq_state_t state_r;
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic [2:0] func_r;
    logic [7:0] result_r;
    logic       done_r;

    // Two-flop synchroniser for both raw pushbuttons (idle level is high).
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_meta_r <= 2'b11;
            key_sync_r <= 2'b11;
        end else begin
            key_meta_r <= key_n;
            key_sync_r <= key_meta_r;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_key
        logic [CW-1:0] cnt_r;
        logic          deb_r;
        logic          press_r;

        // Accept a level change only after it has been stable long enough; strobe on press.
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                cnt_r   <= {CW{1'b0}};
                deb_r   <= 1'b1;
                press_r <= 1'b0;
            end else if (key_sync_r[i] == deb_r) begin
                cnt_r   <= {CW{1'b0}};
                press_r <= 1'b0;
            end else if (cnt_r == CNT_LAST) begin
                cnt_r   <= {CW{1'b0}};
                deb_r   <= key_sync_r[i];
                press_r <= ~key_sync_r[i];
            end else begin
                cnt_r   <= cnt_r + CW'(1);
                press_r <= 1'b0;
            end
        end

        assign press_s[i] = press_r;
    end

    // Operand entry sequencer; clear overrides enter in every state.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r  <= GET_A;
            a_r      <= 4'h0;
            b_r      <= 4'h0;
            func_r   <= 3'd0;
            result_r <= 8'h00;
            done_r   <= 1'b0;
        end else if (press_s[1]) begin
            state_r  <= GET_A;
            a_r      <= 4'h0;
            b_r      <= 4'h0;
            func_r   <= 3'd0;
            result_r <= 8'h00;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                GET_A: begin
                    if (press_s[0]) begin
                        a_r     <= sw;
                        state_r <= GET_B;
                    end
                    done_r <= 1'b0;
                end
                GET_B: begin
                    if (press_s[0]) begin
                        b_r     <= sw;
                        state_r <= GET_F;
                    end
                    done_r <= 1'b0;
                end
                GET_F: begin
                    if (press_s[0]) begin
                        func_r  <= sw[2:0];
                        state_r <= CAPTURE;
                    end
                    done_r <= 1'b0;
                end
                CAPTURE: begin
                    // ALU is combinational, so alu_out already reflects A/B/Function.
                    result_r <= alu_out;
                    state_r  <= SHOW;
                    done_r   <= 1'b1;
                end
                SHOW: begin
                    if (press_s[0]) begin
`ifdef ALU_SEQ_CHAIN_EN
                        a_r     <= result_r[3:0];
                        state_r <= GET_B;
`else
                        state_r <= GET_A;
`endif
                        done_r  <= 1'b0;
                    end else begin
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= GET_A;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign A        = a_r;
    assign B        = b_r;
    assign Function = func_r;
    assign result   = result_r;
    assign state    = state_r;
    assign done     = done_r;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed testbench for alu_operand_sequencer with DEBOUNCE_CYCLES=4.
// Build with ALU_SEQ_CHAIN_EN defined to cover the chaining variant.
module tb_alu_operand_sequencer;

    logic       CLOCK_50;
    logic       reset;
    logic [1:0] key_n;
    logic [3:0] sw;
    logic [7:0] alu_out;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] Function;
    logic [7:0] result;
    logic [2:0] state;
    logic       done;

    int tests_run = 0;
    int tests_failed = 0;

    alu_operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .key_n(key_n),
        .sw(sw),
        .alu_out(alu_out),
        .A(A),
        .B(B),
        .Function(Function),
        .result(result),
        .state(state),
        .done(done)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Model ALU: function 0 adds, anything else XORs.
    always_comb begin
        if (Function == 3'd0) alu_out = {4'h0, A} + {4'h0, B};
        else                  alu_out = {4'h0, A ^ B};
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        key_n = 2'b11;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    // Press key and return just after the edge where its effect becomes visible.
    task automatic key_down(input int idx);
        key_n[idx] = 1'b0;
        cyc(7);
    endtask

    task automatic key_up(input int idx);
        key_n[idx] = 1'b1;
        cyc(8);
    endtask

    task automatic enter_value(input logic [3:0] v);
        sw = v;
        key_down(0);
        key_up(0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key_n = 2'b11;
        sw = 4'hA;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("reset_A", {4'h0, A}, 8'h00);
        chk("reset_B", {4'h0, B}, 8'h00);
        chk("reset_F", {5'h00, Function}, 8'h00);
        chk("reset_result", result, 8'h00);
        chk("reset_state", {5'h00, state}, 8'h00);
        chk("reset_done", {7'h00, done}, 8'h00);
        cyc(20);
        chk("idle_state", {5'h00, state}, 8'h00);
        chk("idle_A", {4'h0, A}, 8'h00);
    endtask

    task automatic test_full_entry();
        do_reset();
        sw = 4'h3;
        key_down(0);
        chk("entry_state1", {5'h00, state}, 8'h01);
        chk("entry_A", {4'h0, A}, 8'h03);
        key_up(0);
        sw = 4'h5;
        key_down(0);
        chk("entry_state2", {5'h00, state}, 8'h02);
        chk("entry_B", {4'h0, B}, 8'h05);
        key_up(0);
        sw = 4'h0;
        key_down(0);
        chk("entry_state3", {5'h00, state}, 8'h03);
        chk("capture_done", {7'h00, done}, 8'h00);
        chk("capture_result_old", result, 8'h00);
        cyc(1);
        chk("entry_state4", {5'h00, state}, 8'h04);
        chk("entry_result", result, 8'h08);
        chk("entry_done", {7'h00, done}, 8'h01);
        chk("entry_F", {5'h00, Function}, 8'h00);
        key_up(0);
        sw = 4'hF;
        cyc(5);
        chk("show_hold_state", {5'h00, state}, 8'h04);
        chk("show_hold_A", {4'h0, A}, 8'h03);
        chk("show_hold_result", result, 8'h08);
    endtask

    task automatic test_key_timing();
        do_reset();
        sw = 4'h7;
        key_n[0] = 1'b0;
        cyc(6);
        chk("timing_before", {5'h00, state}, 8'h00);
        cyc(1);
        chk("timing_after", {5'h00, state}, 8'h01);
        chk("timing_A", {4'h0, A}, 8'h07);
        cyc(13);
        chk("hold_one_pulse", {5'h00, state}, 8'h01);
        key_up(0);
        chk("release_no_pulse", {5'h00, state}, 8'h01);
        key_n[0] = 1'b0;
        cyc(2);
        key_n[0] = 1'b1;
        cyc(10);
        chk("glitch_state", {5'h00, state}, 8'h01);
        chk("glitch_B", {4'h0, B}, 8'h00);
    endtask

    task automatic test_clear();
        do_reset();
        enter_value(4'h3);
        enter_value(4'h5);
        enter_value(4'h0);
        cyc(1);
        chk("clr_pre_result", result, 8'h08);
        key_down(1);
        chk("clr_show_result", result, 8'h00);
        chk("clr_show_state", {5'h00, state}, 8'h00);
        chk("clr_show_done", {7'h00, done}, 8'h00);
        key_up(1);
        enter_value(4'h9);
        enter_value(4'h6);
        chk("clr_pre_state", {5'h00, state}, 8'h02);
        key_down(1);
        chk("clr_getf_state", {5'h00, state}, 8'h00);
        chk("clr_getf_A", {4'h0, A}, 8'h00);
        chk("clr_getf_B", {4'h0, B}, 8'h00);
        key_up(1);
        enter_value(4'hC);
        enter_value(4'h2);
        sw = 4'h5;
        key_n = 2'b00;
        cyc(7);
        chk("both_state", {5'h00, state}, 8'h00);
        chk("both_A", {4'h0, A}, 8'h00);
        chk("both_F", {5'h00, Function}, 8'h00);
        key_n = 2'b11;
        cyc(8);
        chk("both_after", {5'h00, state}, 8'h00);
    endtask

    task automatic test_reset_mid();
        do_reset();
        enter_value(4'h9);
        chk("mid_pre_A", {4'h0, A}, 8'h09);
        sw = 4'h4;
        key_n[0] = 1'b0;
        cyc(3);
        reset = 1'b1;
        key_n[0] = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        chk("mid_state", {5'h00, state}, 8'h00);
        chk("mid_A", {4'h0, A}, 8'h00);
        cyc(20);
        chk("mid_no_pulse_state", {5'h00, state}, 8'h00);
        chk("mid_no_pulse_A", {4'h0, A}, 8'h00);
        chk("mid_no_pulse_B", {4'h0, B}, 8'h00);
    endtask

    task automatic test_show_enter();
        do_reset();
        enter_value(4'h3);
        enter_value(4'h5);
        enter_value(4'h0);
        sw = 4'hC;
        key_down(0);
`ifdef ALU_SEQ_CHAIN_EN
        chk("show_enter_state", {5'h00, state}, 8'h01);
        chk("show_enter_A", {4'h0, A}, 8'h08);
`else
        chk("show_enter_state", {5'h00, state}, 8'h00);
        chk("show_enter_A", {4'h0, A}, 8'h03);
`endif
        chk("show_enter_B", {4'h0, B}, 8'h05);
        chk("show_enter_result", result, 8'h08);
        chk("show_enter_done", {7'h00, done}, 8'h00);
        key_up(0);
    endtask

    initial begin
        reset = 1'b1;
        key_n = 2'b11;
        sw = 4'h0;
        test_reset();
        test_full_entry();
        test_key_timing();
        test_clear();
        test_reset_mid();
        test_show_enter();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
